// File: rtl/util_dac_diff_player.sv
// Serializes FWFT FIFO words MSB-first onto a p/n differential DAC code.
// Back-to-back words stream gap-free; the pair idles at 00 otherwise.
module util_dac_diff_player #(
  parameter int CLK_DIV    = 50,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rd_valid,
  input  logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic [1:0]            diff_out,
  output logic                  active,
  output logic                  done
);

  localparam int              BCW      = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [15:0]     DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(WORD_WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [15:0]           r_div;
  logic [BCW-1:0]        r_bit_cnt;
  logic                  r_rd_en;
  logic                  r_done;

  logic w_tick;
  logic w_last;
  logic w_start;
  logic w_load;
  logic w_done_nxt;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_last  = w_tick && (r_bit_cnt == BIT_LAST);
  assign w_start = enable && rd_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)            w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last && !w_start) w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // Decides the registered strobes for the next cycle; enable is only seen at word boundaries.
  always_comb begin
    w_load     = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE:  w_load = w_start;
      S_SHIFT: begin
        w_load     = w_last && w_start;
        w_done_nxt = w_last && !w_start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_rd_en   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en <= w_load;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_shift   <= rd_data;
        r_div     <= '0;
        r_bit_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        if (w_tick) begin
          r_div <= '0;
          if (!w_last) begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_bit_cnt <= '0;
          end
        end else begin
          r_div <= r_div + 16'd1;
        end
      end
    end
  end

  // Outputs decode flops only, so no input reaches them combinationally.
  assign rd_en    = r_rd_en;
  assign done     = r_done;
  assign active   = (r_state == S_SHIFT);
  assign diff_out = active ? (r_shift[WORD_WIDTH-1] ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_util_dac_diff_player.sv
// Randomized bench for util_dac_diff_player against a word/position reference model,
// with a small FWFT FIFO model feeding the DUT.
module tb_util_dac_diff_player;

  localparam int CLK_DIV = 4;
  localparam int WW      = 8;
  localparam int BIT_CYC = CLK_DIV * WW;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          rd_valid;
  logic [WW-1:0] rd_data;
  logic          rd_en;
  logic [1:0]    diff_out;
  logic          active;
  logic          done;

  util_dac_diff_player #(.CLK_DIV(CLK_DIV), .WORD_WIDTH(WW)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_en    (rd_en),
    .diff_out (diff_out),
    .active   (active),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] fifo[$];
  logic          gate;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_pops   = 0;
  int            n_done   = 0;
  int            cyc      = 0;
  int            last_pop = -1;
  bit            track_gap = 0;
  string         phase = "reset";

  // Reference model: which word is playing and how many cycles into it we are.
  bit            m_busy  = 0;
  bit            m_rd_en = 0;
  bit            m_done  = 0;
  int            m_pos   = 0;
  logic [WW-1:0] m_word  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s at cycle %0d: got %0h expected %0h", phase, tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    rd_valid = gate && (fifo.size() > 0);
    rd_data  = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic step();
    bit         pop_now;
    logic [1:0] exp_diff;
    pop_now = m_rd_en;
    if (rst) begin
      m_busy = 0; m_rd_en = 0; m_done = 0; m_pos = 0;
    end else begin
      m_rd_en = 0;
      m_done  = 0;
      if (!m_busy || m_pos == BIT_CYC - 1) begin
        if (enable && rd_valid) begin
          m_busy = 1; m_word = rd_data; m_pos = 0; m_rd_en = 1;
        end else if (m_busy) begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
    #1;
    cyc++;
    exp_diff = m_busy ? (m_word[WW-1-(m_pos/CLK_DIV)] ? 2'b10 : 2'b01) : 2'b00;
    chk("outs", {27'd0, diff_out, active, rd_en, done}, {27'd0, exp_diff, m_busy, m_rd_en, m_done});
    if (done) n_done++;
    if (rd_en) begin
      if (track_gap && last_pop >= 0) chk("pop_gap", cyc - last_pop, BIT_CYC);
      last_pop = cyc;
      n_pops++;
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (m_busy && k < budget);
    if (m_busy) chk("drain_timeout", k, budget + 1);
  endtask

  task automatic clear_counts();
    n_pops = 0;
    n_done = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; gate = 1'b1;
    fifo.push_back(8'h5A);
    drive();

    phase = "t1_reset";
    repeat (4) step();
    chk("pops_in_reset", n_pops, 0);
    rst = 1'b0;
    step();
    chk("first_pop", {31'd0, rd_en}, 1);
    drain(200);
    step();

    phase = "t2_single";
    clear_counts();
    fifo.push_back(8'hA5); drive();
    drain(200);
    chk("pops", n_pops, 1);
    chk("dones", n_done, 1);

    phase = "t3_stream";
    clear_counts();
    fifo.push_back(8'hFF); fifo.push_back(8'h00); drive();
    track_gap = 1; last_pop = -1;
    drain(300);
    track_gap = 0;
    chk("pops", n_pops, 2);
    chk("dones", n_done, 1);

    phase = "t4_en_drop";
    clear_counts();
    fifo.push_back(8'h81); fifo.push_back(8'h81); drive();
    repeat (1 + 3 * CLK_DIV) step();
    enable = 1'b0;
    drain(200);
    step();
    chk("pops", n_pops, 1);
    chk("dones", n_done, 1);
    fifo.delete(); drive();

    phase = "t5_disabled";
    clear_counts();
    fifo.push_back(8'h3C); drive();
    repeat (100) step();
    chk("pops_disabled", n_pops, 0);
    enable = 1'b1;
    step();
    chk("pop_on_enable", {31'd0, rd_en}, 1);
    drain(200);
    chk("pops", n_pops, 1);

    phase = "t6_rst_mid";
    clear_counts();
    fifo.push_back(8'hF0); fifo.push_back(8'h3C); drive();
    repeat (1 + 5 * CLK_DIV) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("no_done_on_rst", n_done, 0);
    drain(300);
    chk("pops", n_pops, 2);
    chk("dones", n_done, 1);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if (fifo.size() < 4 && $urandom_range(0, 3) == 0) fifo.push_back(WW'($urandom));
      if ($urandom_range(0, 99) < 3)  enable = ~enable;
      if ($urandom_range(0, 99) < 10) gate = ~gate;
      rst = ($urandom_range(0, 499) == 0);
      drive();
      step();
    end
    rst = 1'b0; enable = 1'b1; gate = 1'b1; drive();
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
